// File: rtl/division_arbiter.sv
// Round-robin front end that shares one 8-bit sequential divider among N_REQ
// requesters: grant, issue a start pulse, wait for done or timeout, respond.
module division_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_dividend,
    input  logic [8*N_REQ-1:0] req_divisor,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [7:0]         resp_quotient,
    output logic [7:0]         resp_remainder,
    output logic               resp_error,
    output logic               busy,
    output logic               div_start,
    output logic [7:0]         div_dividend,
    output logic [7:0]         div_divisor,
    input  logic [7:0]         div_quotient,
    input  logic [7:0]         div_remainder,
    input  logic               div_done,
    input  logic               div_error
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [7:0]    dvd_q, dvd_d;
    logic [7:0]    dvs_q, dvs_d;
    logic [7:0]    timer_q, timer_d;
    logic [7:0]    rq_q, rq_d;
    logic [7:0]    rr_q, rr_d;
    logic          re_q, re_d;

    logic [GW-1:0] pick;
    logic          any_req;
    logic [GW:0]   cand;

    // Round-robin search starting just above the last served requester.
    always_comb begin
        pick    = last_q;
        any_req = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = {1'b0, last_q} + (GW+1)'(off);
            if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
            if (!any_req && req_valid[cand[GW-1:0]]) begin
                pick    = cand[GW-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        timer_d    = timer_q;
        rq_d       = rq_q;
        rr_d       = rr_q;
        re_d       = re_q;
        req_ready  = '0;
        resp_valid = '0;
        div_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    for (int i = 0; i < N_REQ; i++)
                        req_ready[i] = (pick == GW'(i));
                    grant_d = pick;
                    dvd_d   = req_dividend[{pick, 3'b000} +: 8];
                    dvs_d   = req_divisor[{pick, 3'b000} +: 8];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                timer_d   = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 8'd1;
                // A real completion wins over a timeout landing in the same cycle.
                if (div_done) begin
                    rq_d    = div_quotient;
                    rr_d    = div_remainder;
                    re_d    = div_error;
                    state_d = RESP;
                end else if (timer_q == 8'(TIMEOUT_CYC - 1)) begin
                    rq_d    = 8'hFF;
                    rr_d    = 8'hFF;
                    re_d    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                for (int i = 0; i < N_REQ; i++)
                    resp_valid[i] = (grant_q == GW'(i));
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N_REQ - 1);
            dvd_q   <= '0;
            dvs_q   <= '0;
            timer_q <= '0;
            rq_q    <= '0;
            rr_q    <= '0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            timer_q <= timer_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            re_q    <= re_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign div_dividend   = dvd_q;
    assign div_divisor    = dvs_q;
    assign resp_quotient  = rq_q;
    assign resp_remainder = rr_q;
    assign resp_error     = re_q;

endmodule

// File: tb/tb_division_arbiter.sv
// Directed bench for division_arbiter with a behavioural divider that answers
// 10 cycles after start (1 cycle for divisor 0), or never when hung.
module tb_division_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_dividend = '0;
    logic [8*N-1:0] req_divisor = '0;
    logic [N-1:0]   resp_valid;
    logic [7:0]     resp_quotient, resp_remainder;
    logic           resp_error, busy, div_start;
    logic [7:0]     div_dividend, div_divisor, div_quotient, div_remainder;
    logic           div_done, div_error;

    logic [3:0]     cnt;
    logic           hang = 1'b0;
    logic           force_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    division_arbiter #(.N_REQ(N), .TIMEOUT_CYC(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_quotient(resp_quotient),
        .resp_remainder(resp_remainder), .resp_error(resp_error),
        .busy(busy), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_done(div_done), .div_error(div_error)
    );

    always #5 clk = ~clk;

    // Divider model: done pulse arrives L cycles after the start cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (div_start && !hang) cnt <= (div_divisor == 8'd0) ? 4'd1 : 4'd10;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
    assign div_done      = (cnt == 4'd1) || force_done;
    assign div_error     = div_done && (div_divisor == 8'd0);
    assign div_quotient  = (div_divisor == 8'd0) ? 8'hFF : div_dividend / div_divisor;
    assign div_remainder = (div_divisor == 8'd0) ? 8'hFF : div_dividend % div_divisor;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [7:0] dvd, input logic [7:0] dvs);
        req_dividend[8*i +: 8] = dvd;
        req_divisor[8*i +: 8]  = dvs;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] prev;
        logic [N-1:0] exp_g;

        // Reset values
        #3;
        check_eq("rst_ready", 32'(req_ready), 0);
        check_eq("rst_resp_valid", 32'(resp_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_start", 32'(div_start), 0);
        check_eq("rst_quot", 32'(resp_quotient), 0);
        check_eq("rst_dvd", 32'(div_dividend), 0);
        step(); step();
        rst_n = 1'b1;

        // Single request on requester 1: 200/7
        step();
        req_valid = 4'b0010; set_op(1, 8'd200, 8'd7);
        #1 check_eq("t1_ready", 32'(req_ready), 32'b0010);
        check_eq("t1_busy_idle", 32'(busy), 0);
        step(); req_valid = '0;
        #1 check_eq("t1_start", 32'(div_start), 1);
        check_eq("t1_dvd", 32'(div_dividend), 200);
        check_eq("t1_dvs", 32'(div_divisor), 7);
        repeat (10) step();
        #1 check_eq("t1_no_early_resp", 32'(resp_valid), 0);
        check_eq("t1_dvd_stable", 32'(div_dividend), 200);
        step();
        #1 check_eq("t1_resp_valid", 32'(resp_valid), 32'b0010);
        check_eq("t1_quot", 32'(resp_quotient), 28);
        check_eq("t1_rem", 32'(resp_remainder), 4);
        check_eq("t1_err", 32'(resp_error), 0);
        step();
        #1 check_eq("t1_busy_after", 32'(busy), 0);
        check_eq("t1_resp_pulse", 32'(resp_valid), 0);
        check_eq("t1_quot_hold", 32'(resp_quotient), 28);

        // Requester 2: 55/0
        step();
        req_valid = 4'b0100; set_op(2, 8'd55, 8'd0);
        #1 check_eq("t2_ready", 32'(req_ready), 32'b0100);
        step(); req_valid = '0;
        #1 check_eq("t2_start", 32'(div_start), 1);
        step();
        #1 check_eq("t2_no_resp_t2", 32'(resp_valid), 0);
        step();
        #1 check_eq("t2_resp_valid", 32'(resp_valid), 32'b0100);
        check_eq("t2_quot", 32'(resp_quotient), 32'hFF);
        check_eq("t2_rem", 32'(resp_remainder), 32'hFF);
        check_eq("t2_err", 32'(resp_error), 1);
        check_eq("t2_busy_resp", 32'(busy), 1);
        step();
        #1 check_eq("t2_busy_fall", 32'(busy), 0);

        // All four held valid with 100/10 after a fresh reset
        step(); rst_n = 1'b0;
        #1 check_eq("t3_rst_busy", 32'(busy), 0);
        step(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 8'd100, 8'd10);
        req_valid = 4'b1111;
        prev = '0;
        for (int k = 0; k < 5; k++) begin
            exp_g = N'(1 << (k % N));
            #1 check_eq($sformatf("t3_grant%0d", k), 32'(req_ready), 32'(exp_g));
            check_eq($sformatf("t3_not_repeat%0d", k), 32'(req_ready == prev), 0);
            prev = req_ready;
            repeat (12) step();
            #1 check_eq($sformatf("t3_resp%0d", k), 32'(resp_valid), 32'(exp_g));
            check_eq($sformatf("t3_quot%0d", k), 32'(resp_quotient), 10);
            check_eq($sformatf("t3_rem%0d", k), 32'(resp_remainder), 0);
            step();
        end

        // Timeout: divider hangs; requesters 1 and 2 pending (last grant was 0)
        hang = 1'b1;
        req_valid = 4'b0110;
        #1 check_eq("t4_ready", 32'(req_ready), 32'b0010);
        repeat (32) step();
        #1 check_eq("t4_no_early_resp", 32'(resp_valid), 0);
        step();
        #1 check_eq("t4_resp_valid", 32'(resp_valid), 32'b0010);
        check_eq("t4_quot", 32'(resp_quotient), 32'hFF);
        check_eq("t4_rem", 32'(resp_remainder), 32'hFF);
        check_eq("t4_err", 32'(resp_error), 1);
        hang = 1'b0;
        req_valid = 4'b0100; set_op(2, 8'd9, 8'd4);
        step();
        #1 check_eq("t4_next_grant", 32'(req_ready), 32'b0100);
        step(); req_valid = '0;
        repeat (11) step();
        #1 check_eq("t4_resp2", 32'(resp_valid), 32'b0100);
        check_eq("t4_quot2", 32'(resp_quotient), 2);
        check_eq("t4_rem2", 32'(resp_remainder), 1);
        check_eq("t4_err2", 32'(resp_error), 0);

        // Spurious done in IDLE
        step(); force_done = 1'b1;
        #1 check_eq("t5_spur_resp", 32'(resp_valid), 0);
        step(); force_done = 1'b0;
        #1 check_eq("t5_spur_resp_next", 32'(resp_valid), 0);
        check_eq("t5_spur_busy", 32'(busy), 0);
        check_eq("t5_spur_quot_hold", 32'(resp_quotient), 2);

        // Reset during WAIT
        req_valid = 4'b1000; set_op(3, 8'd50, 8'd5);
        #1 check_eq("t5_ready3", 32'(req_ready), 32'b1000);
        step(); req_valid = '0;
        step(); step();
        rst_n = 1'b0;
        #1 check_eq("t5_rst_busy", 32'(busy), 0);
        check_eq("t5_rst_dvd", 32'(div_dividend), 0);
        check_eq("t5_rst_dvs", 32'(div_divisor), 0);
        check_eq("t5_rst_quot", 32'(resp_quotient), 0);
        check_eq("t5_rst_rem", 32'(resp_remainder), 0);
        check_eq("t5_rst_err", 32'(resp_error), 0);
        check_eq("t5_rst_start", 32'(div_start), 0);
        check_eq("t5_rst_ready", 32'(req_ready), 0);
        step(); step();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1 check_eq($sformatf("t5_no_resp%0d", c), 32'(resp_valid), 0);
            step();
        end
        req_valid = 4'b1111;
        #1 check_eq("t5_first_grant", 32'(req_ready), 32'b0001);
        step(); req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/division_arbiter.md
# division_arbiter

Round-robin arbiter and sequencer that shares one 8-bit sequential divider among `N_REQ` requesters. It accepts one division request at a time, launches the divider with a single-cycle start pulse, and waits for the divider's done/error pulse or a watchdog timeout. It then returns quotient, remainder and error to the granted requester as a one-cycle response. It sits between the client blocks and the divider's `start`/`i_dividend`/`i_divisor`/`o_quotient`/`o_remainder`/`done`/`error` ports.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, default 31: cycles in WAIT without `div_done` before forcing an error response; range 12..255.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester request; held with operands until accepted.
- `req_ready`  out  N_REQ  one-hot grant; transfer happens on `req_valid[i] & req_ready[i]`.
- `req_dividend`  in  8*N_REQ  operands; requester i uses bits [8i+7:8i].
- `req_divisor`  in  8*N_REQ  operands; same packing.
- `resp_valid`  out  N_REQ  one-cycle pulse to the served requester.
- `resp_quotient`  out  8  result, valid with `resp_valid`.
- `resp_remainder`  out  8  result, valid with `resp_valid`.
- `resp_error`  out  1  divide-by-zero or timeout, valid with `resp_valid`.
- `busy`  out  1  high whenever state != IDLE.
- `div_start`  out  1  divider start pulse.
- `div_dividend`  out  8  divider operand.
- `div_divisor`  out  8  divider operand.
- `div_quotient`  in  8  divider result.
- `div_remainder`  in  8  divider result.
- `div_done`  in  1  divider completion pulse.
- `div_error`  in  1  divider divide-by-zero pulse, coincident with `div_done`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, compute grant g by round robin: search from `last_grant+1` upward, wrapping at `N_REQ-1`.
  - `req_ready[g]` is combinational, high only in IDLE.
  - At the clock edge, latch g and requester g's dividend/divisor, then go to ISSUE.
  - With no requests, stay in IDLE; `req_ready` is all zero.
- ISSUE: `div_start=1` for exactly this cycle. `div_dividend`/`div_divisor` come from the latched registers and stay stable from ISSUE through RESP. Clear the timer and go to WAIT.
- WAIT: the timer increments every cycle.
  - If `div_done=1`: latch `div_quotient`, `div_remainder` and `div_error` into the response registers, then go to RESP.
  - Otherwise, if the timer reaches `TIMEOUT_CYC-1`: latch quotient=8'hFF, remainder=8'hFF, error=1, then go to RESP.
  - `div_done` takes priority over timeout in the same cycle.
- RESP: `resp_valid[g]=1` for one cycle. Set `last_grant<=g` and go to IDLE.
- `div_done`/`div_error` seen outside WAIT are ignored.
- The arbiter does not check the divisor. Zero divisors pass through, and the divider's error response (FF/FF, error=1) is forwarded unchanged.
- The timer is 8 bits wide; comparisons are unsigned.

## Timing
- Reset values:
  - `req_ready`, `resp_valid`, `div_start`, `busy` = 0.
  - `resp_quotient`, `resp_remainder` = 8'h00; `resp_error` = 0.
  - `div_dividend`, `div_divisor` = 8'h00.
  - `last_grant` = N_REQ-1, so requester 0 wins first.
- Grant cycle T has `req_ready` high.
  - `div_start` is high in T+1.
  - Normal divide: `div_done` arrives in T+11 (8 CALC cycles, then FINISH, then registered done); `resp_valid` is high in T+12.
  - Divisor 0: `div_done`/`div_error` arrive in T+2; `resp_valid` is high in T+3.
  - Timeout: `resp_valid` is high in T+2+TIMEOUT_CYC.
- Next grant: the earliest is the cycle after RESP, i.e. T+13 for a normal divide.
- `resp_quotient`, `resp_remainder` and `resp_error` hold their value until the next response.
- A requester that deasserts `req_valid` before `req_ready` is simply not served; there is no penalty.
- Reset mid-operation returns all state to the reset values immediately. The divider shares `rst_n`, and no response is produced for the aborted request.

## Test plan
- Single request on requester 1, 200/7 -> `req_ready[1]` in T, `div_start` in T+1, `resp_valid[1]` in T+12 with quotient 28, remainder 4, error 0.
- Requester 2 divides 55/0 -> `resp_valid[2]` in T+3 with FF/FF, error 1; `busy` falls in T+4.
- All four requesters held valid continuously, each dividing 100/10 -> grants in order 0,1,2,3,0; each `resp_valid` carries 10/0; no requester is granted twice in a row.
- Divider model never pulses `div_done`, TIMEOUT_CYC=31 -> `resp_valid[g]` in T+33 with FF/FF, error 1; the arbiter then grants the next pending request.
- Spurious `div_done` while in IDLE, and `rst_n` low during WAIT -> no `resp_valid`. After reset, all outputs are at their reset values and requester 0 wins the next grant.
